seq_det_param: RTL and testbench
================================

SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 SHALL have parameter N, default 8, legal 2..32: maximum pattern length in bits.
REQ-002 SHALL have parameter CNT_W, default 8: match counter width.
REQ-003 SHALL derive LW = $clog2(N+1): length field width.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  qualifies in on this edge.
REQ-007 SHALL have port in  input  1  serial data bit.
REQ-008 SHALL have port cfg_load  input  1  latch configuration strobe.
REQ-009 SHALL have port cfg_pat  input  N  pattern; pat[len-1] is the first bit received, pat[0] the last.
REQ-010 SHALL have port cfg_len  input  LW  active pattern length.
REQ-011 SHALL have port cfg_overlap  input  1  1 = overlapping matches, 0 = non-overlapping.
REQ-012 SHALL have port clr_cnt  input  1  synchronous clear of match_cnt.
REQ-013 SHALL have port out  output  1  registered one-cycle match pulse.
REQ-014 SHALL have port match_cnt  output  CNT_W  saturating match count.
REQ-015 SHALL have port armed  output  1  high when fill >= len_r.

Function
REQ-016 SHALL hold the registers pat_r (N), len_r (LW), ovl_r, hist (N), fill (LW), out and match_cnt.
REQ-017 On cfg_load=1, SHALL latch cfg_pat, cfg_overlap and len_r = cfg_len, with len_r = N if cfg_len is 0 or greater than N; SHALL clear hist and fill; SHALL drive out=0 next cycle.
REQ-018 cfg_load SHALL take priority over in_valid on the same edge; that in bit is discarded and match_cnt is unchanged.
REQ-019 On in_valid=1 without cfg_load, SHALL update hist_n = {hist[N-2:0], in} and fill_n = min(fill+1, len_r).
REQ-020 A match SHALL occur when in_valid=1, fill_n == len_r and hist_n[len_r-1:0] == pat_r[len_r-1:0].
REQ-021 out SHALL be 1 for exactly the one cycle after the edge that sampled the completing bit, and 0 otherwise.
REQ-022 On a match with ovl_r=1, fill SHALL stay at len_r, so a suffix/prefix overlap can match again.
REQ-023 On a match with ovl_r=0, fill SHALL go to 0, so the next match needs len_r fresh bits.
REQ-024 On in_valid=0, hist and fill SHALL hold and out SHALL be 0; gaps of any length are transparent.
REQ-025 match_cnt SHALL increment by 1 per match and saturate at 2^CNT_W-1 without wrapping.
REQ-026 On clr_cnt=1, match_cnt SHALL go to 0; clr_cnt wins over a simultaneous match, but out still pulses.
REQ-027 armed SHALL be a combinational decode of the fill and len_r registers.

Reset
REQ-028 While rst=1, asynchronously and independent of clk: pat_r=0, len_r=N, ovl_r=1, hist=0, fill=0, out=0, match_cnt=0, armed=0.
REQ-029 The first rising edge after rst deasserts SHALL operate normally; there is no stretch cycle.
REQ-030 Reset mid-stream SHALL discard partial history; a match SHALL need len_r fresh valid bits after release.

Verification
REQ-031 Overlap: with N=8, load pat=0000_1011, len=4, overlap=1, stream 1,0,1,1,0,1,1 (all valid) -> out pulses after bits 4 and 7; match_cnt=2.
REQ-032 Non-overlap: same stream with overlap=0 -> out pulses only after bit 4; match_cnt=1; armed=0 immediately after the match.
REQ-033 Gaps and reload: stream 1,0, then in_valid=0 for 3 cycles, then 1,1 -> one pulse. Separately, stream 1,0,1, then cfg_load with the same config, then 1 -> no pulse.
REQ-034 Length clamp: cfg_len=0, pat=8'b0111_0010 -> len_r=8; stream 0,1,1,1,0,0,1,0 -> pulse after bit 8; no pulse earlier.
REQ-035 Saturation: CNT_W=2, 5 matches -> match_cnt=3; clr_cnt on the edge of a 6th match -> match_cnt=0 and out=1.
REQ-036 Async reset: assert rst between clock edges mid-stream -> out, match_cnt, fill and armed are 0 before the next edge; after release a full pattern is needed to match.

Source files
------------

// File: rtl/seq_det_param.sv
// rtl/seq_det_param.sv - configurable serial pattern detector with overlap control and saturating match counter
//
// Purpose:
//   Watches a qualified serial bit stream for a runtime-loaded pattern of
//   1..N bits. Each completed match produces a one-cycle registered pulse
//   on out and increments match_cnt, which saturates at its maximum value.
//   Overlapping mode lets a suffix of one match serve as the prefix of the
//   next. Non-overlapping mode requires len_r fresh bits after each match.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   in_valid     in   qualifies in on this edge
//   in           in   serial data bit
//   cfg_load     in   latch cfg_pat/cfg_len/cfg_overlap; clears history
//   cfg_pat      in   [N-1:0] pattern, pat[len-1] is the first bit received
//   cfg_len      in   [LW-1:0] pattern length, 0 or >N selects N
//   cfg_overlap  in   1 = overlapping matches, 0 = non-overlapping
//   clr_cnt      in   synchronous clear of match_cnt
//   out          out  one-cycle match pulse (registered)
//   match_cnt    out  [CNT_W-1:0] saturating match count
//   armed        out  fill has reached the active length
module seq_det_param #(
  parameter int N     = 8,
  parameter int CNT_W = 8,
  localparam int LW   = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             cfg_load,
  input  logic [N-1:0]     cfg_pat,
  input  logic [LW-1:0]    cfg_len,
  input  logic             cfg_overlap,
  input  logic             clr_cnt,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  localparam logic [LW-1:0]    LEN_MAX = LW'(N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N-1:0]     pat_q;
  logic [LW-1:0]    len_q;
  logic             ovl_q;
  logic [N-1:0]     hist_q;
  logic [LW-1:0]    fill_q;
  logic             out_q;
  logic [CNT_W-1:0] cnt_q;

  logic [N-1:0]     hist_d;
  logic [LW-1:0]    fill_d;
  logic [LW-1:0]    len_d;
  logic [N-1:0]     mask;
  logic             match_d;

  always_comb begin
    hist_d = {hist_q[N-2:0], in};
    // fill counts valid bits since the last clear, capped at the active length
    fill_d = (fill_q >= len_q) ? len_q : fill_q + LW'(1);
    len_d  = ((cfg_len == '0) || (cfg_len > LEN_MAX)) ? LEN_MAX : cfg_len;
    // Low len_q bits set; a shift by N leaves zero, so len_q == N gives all ones
    mask   = ~({N{1'b1}} << len_q);
    match_d = in_valid && !cfg_load && (fill_d == len_q) &&
              (((hist_d ^ pat_q) & mask) == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q  <= '0;
      len_q  <= LEN_MAX;
      ovl_q  <= 1'b1;
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      out_q <= match_d;

      if (cfg_load) begin
        // The in bit on a load edge is discarded along with the old history
        pat_q  <= cfg_pat;
        len_q  <= len_d;
        ovl_q  <= cfg_overlap;
        hist_q <= '0;
        fill_q <= '0;
      end else if (in_valid) begin
        hist_q <= hist_d;
        fill_q <= (match_d && !ovl_q) ? '0 : fill_d;
      end

      // Clear beats a simultaneous match; the pulse on out is unaffected
      if (clr_cnt) begin
        cnt_q <= '0;
      end else if (match_d && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign out       = out_q;
  assign match_cnt = cnt_q;
  assign armed     = (fill_q >= len_q);

endmodule

// File: tb/tb_seq_det_param.sv
// tb/tb_seq_det_param.sv - self-checking bench for seq_det_param
module tb_seq_det_param;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_bit;
  logic       cfg_load;
  logic [7:0] cfg_pat;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       clr_cnt;

  logic       out8, armed8, out2, armed2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int tests_run;
  int tests_failed;

  // Reference model: the valid bits received since the last clear, oldest first
  bit   q[$];
  bit [7:0] mpat;
  int   mlen;
  bit   movl;
  bit   eout;
  int   ecnt8;
  int   ecnt2;

  seq_det_param #(.N(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit),
    .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .clr_cnt(clr_cnt),
    .out(out8), .match_cnt(cnt8), .armed(armed8)
  );

  seq_det_param #(.N(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit),
    .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .clr_cnt(clr_cnt),
    .out(out2), .match_cnt(cnt2), .armed(armed2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    mpat  = 8'h00;
    mlen  = 8;
    movl  = 1'b1;
    eout  = 1'b0;
    ecnt8 = 0;
    ecnt2 = 0;
  endtask

  task automatic model_edge(input bit ld, input bit v, input bit b, input bit clr);
    bit hit;
    hit = 1'b0;
    if (ld) begin
      mpat = cfg_pat;
      mlen = ((cfg_len == 0) || (cfg_len > 8)) ? 8 : int'(cfg_len);
      movl = cfg_overlap;
      q.delete();
    end else if (v) begin
      q.push_back(b);
      if (q.size() > 8) void'(q.pop_front());
      if (q.size() >= mlen) begin
        hit = 1'b1;
        for (int k = 0; k < mlen; k++)
          if (q[q.size() - 1 - k] != mpat[k]) hit = 1'b0;
      end
      if (hit && !movl) q.delete();
    end
    eout = hit;
    if (clr) begin
      ecnt8 = 0;
      ecnt2 = 0;
    end else if (hit) begin
      if (ecnt8 < 255) ecnt8++;
      if (ecnt2 < 3) ecnt2++;
    end
  endtask

  // Drive one edge's inputs, advance the model, then settle 1 time unit past the edge
  task automatic cycle(input bit ld, input bit v, input bit b, input bit clr);
    cfg_load = ld;
    in_valid = v;
    in_bit   = b;
    clr_cnt  = clr;
    model_edge(ld, v, b, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_pat     = p;
    cfg_len     = l;
    cfg_overlap = o;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0; clr_cnt = 1'b0;
    cfg_pat = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
    model_reset();
    #12;
    tests_run++;
    if (out8 !== 1'b0 || out2 !== 1'b0) begin
      tests_failed++; $display("FAIL reset_out got %b/%b want 0", out8, out2);
    end
    tests_run++;
    if (cnt8 !== 8'd0 || cnt2 !== 2'd0) begin
      tests_failed++; $display("FAIL reset_cnt got %0d/%0d want 0", cnt8, cnt2);
    end
    tests_run++;
    if (armed8 !== 1'b0 || armed2 !== 1'b0) begin
      tests_failed++; $display("FAIL reset_armed got %b/%b want 0", armed8, armed2);
    end
    rst = 1'b0;
  endtask

  task automatic run_stream7(input bit ovl, input string name);
    bit stream [7];
    bit want   [7];
    stream = '{1, 0, 1, 1, 0, 1, 1};
    if (ovl) want = '{0, 0, 0, 1, 0, 0, 1};
    else     want = '{0, 0, 0, 1, 0, 0, 0};
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    load_cfg(8'b0000_1011, 4'd4, ovl);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 1'b1, stream[i], 1'b0);
      tests_run++;
      if (out8 !== want[i]) begin
        tests_failed++; $display("FAIL %s_out bit %0d got %b want %b", name, i + 1, out8, want[i]);
      end
      if (!ovl && i == 3) begin
        tests_run++;
        if (armed8 !== 1'b0) begin
          tests_failed++; $display("FAIL %s_armed_after_match got %b want 0", name, armed8);
        end
      end
    end
    tests_run++;
    if (cnt8 !== (ovl ? 8'd2 : 8'd1)) begin
      tests_failed++; $display("FAIL %s_cnt got %0d want %0d", name, cnt8, ovl ? 2 : 1);
    end
  endtask

  task automatic test_overlap();
    run_stream7(1'b1, "overlap");
  endtask

  task automatic test_nonoverlap();
    run_stream7(1'b0, "nonoverlap");
  endtask

  task automatic test_gaps_reload();
    int pulses;
    load_cfg(8'b0000_1011, 4'd4, 1'b1);
    pulses = 0;
    cycle(1'b0, 1'b1, 1'b1, 1'b0); pulses += out8;
    cycle(1'b0, 1'b1, 1'b0, 1'b0); pulses += out8;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0); pulses += out8;
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b0); pulses += out8;
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    tests_run++;
    if (pulses !== 0 || out8 !== 1'b1) begin
      tests_failed++; $display("FAIL gaps got early=%0d final=%b want early=0 final=1", pulses, out8);
    end
    load_cfg(8'b0000_1011, 4'd4, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    load_cfg(8'b0000_1011, 4'd4, 1'b1);
    tests_run++;
    if (out8 !== 1'b0 || armed8 !== 1'b0) begin
      tests_failed++; $display("FAIL reload_clear got out=%b armed=%b want 0/0", out8, armed8);
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    tests_run++;
    if (out8 !== 1'b0) begin
      tests_failed++; $display("FAIL reload_no_pulse got %b want 0", out8);
    end
  endtask

  task automatic test_clamp();
    bit stream [8];
    stream = '{0, 1, 1, 1, 0, 0, 1, 0};
    for (int t = 0; t < 2; t++) begin
      // cfg_len of 0 and of 15 both select the full length of 8
      load_cfg(8'b0111_0010, (t == 0) ? 4'd0 : 4'd15, 1'b1);
      for (int i = 0; i < 8; i++) begin
        cycle(1'b0, 1'b1, stream[i], 1'b0);
        tests_run++;
        if (out8 !== (i == 7)) begin
          tests_failed++; $display("FAIL clamp%0d bit %0d got %b want %b", t, i + 1, out8, i == 7);
        end
      end
    end
  endtask

  task automatic test_saturation();
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    load_cfg(8'b0000_0001, 4'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
    end
    tests_run++;
    if (cnt2 !== 2'd3 || cnt8 !== 8'd5) begin
      tests_failed++; $display("FAIL saturate got %0d/%0d want 3/5", cnt2, cnt8);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    tests_run++;
    if (cnt2 !== 2'd0 || cnt8 !== 8'd0 || out2 !== 1'b1 || out8 !== 1'b1) begin
      tests_failed++;
      $display("FAIL clr_on_match got cnt=%0d/%0d out=%b/%b want 0/0 1/1", cnt2, cnt8, out2, out8);
    end
  endtask

  task automatic test_async_reset();
    load_cfg(8'h00, 4'd0, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (out8 !== 1'b1 || armed8 !== 1'b1) begin
      tests_failed++; $display("FAIL prereset got out=%b armed=%b want 1/1", out8, armed8);
    end
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if (out8 !== 1'b0 || cnt8 !== 8'd0 || armed8 !== 1'b0 || cnt2 !== 2'd0) begin
      tests_failed++;
      $display("FAIL async_reset got out=%b cnt=%0d armed=%b want 0/0/0", out8, cnt8, armed8);
    end
    #1 rst = 1'b0;
    model_reset();
    // Default config after reset is pattern 0, length 8: eight fresh zeros are needed
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      tests_run++;
      if (out8 !== (i == 7)) begin
        tests_failed++; $display("FAIL postreset bit %0d got %b want %b", i + 1, out8, i == 7);
      end
    end
  endtask

  task automatic test_random();
    bit ld, v, b, clr;
    for (int n = 0; n < 3000; n++) begin
      ld  = ($urandom_range(0, 99) < 3);
      clr = !ld && ($urandom_range(0, 99) < 2);
      v   = ($urandom_range(0, 99) < 75);
      b   = $urandom_range(0, 1);
      if (ld) begin
        cfg_pat     = 8'($urandom);
        cfg_len     = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 4)) : 4'($urandom_range(0, 15));
        cfg_overlap = $urandom_range(0, 1);
      end
      cycle(ld, v, b, clr);
      tests_run++;
      if (out8 !== eout || out2 !== eout) begin
        tests_failed++; $display("FAIL rand_out cyc %0d got %b/%b want %b", n, out8, out2, eout);
      end
      tests_run++;
      if (cnt8 !== 8'(ecnt8) || cnt2 !== 2'(ecnt2)) begin
        tests_failed++; $display("FAIL rand_cnt cyc %0d got %0d/%0d want %0d/%0d", n, cnt8, cnt2, ecnt8, ecnt2);
      end
      tests_run++;
      if (armed8 !== (q.size() >= mlen) || armed2 !== (q.size() >= mlen)) begin
        tests_failed++; $display("FAIL rand_armed cyc %0d got %b/%b want %b", n, armed8, armed2, q.size() >= mlen);
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_gaps_reload();
    test_clamp();
    test_saturation();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
